// File: rtl/divu_hilo_unit_pkg.sv
// rtl/divu_hilo_unit_pkg.sv - shared definitions for the divu HI/LO unit
// Purpose : divider FSM state encoding, default operand width and the
//           funct codes of the instructions that drive this unit.
// Ports   : none (package).
package divu_hilo_unit_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   localparam int DEFAULT_WIDTH = 32;

   localparam logic [5:0] FUNCT_DIVU = 6'd27;
   localparam logic [5:0] FUNCT_MFHI = 6'd16;
   localparam logic [5:0] FUNCT_MFLO = 6'd18;

endpackage

// File: rtl/divu_hilo_unit_step.sv
// rtl/divu_hilo_unit_step.sv - one combinational restoring-division step
// Purpose : shifts {rem,quo} left by one and conditionally subtracts dsr,
//           producing the next partial remainder and quotient.
// Ports   : rem, quo, dsr  (in,  WIDTH) current remainder, quotient, divisor
//           rem_next       (out, WIDTH) remainder after this step
//           quo_next       (out, WIDTH) quotient after this step
module divu_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem,
   input  logic [WIDTH-1:0] quo,
   input  logic [WIDTH-1:0] dsr,
   output logic [WIDTH-1:0] rem_next,
   output logic [WIDTH-1:0] quo_next
);

   // Remainder widened by one bit so the shifted-in MSB never overflows
   // the comparison against the divisor.
   logic [WIDTH:0] tmp_rem;
   logic [WIDTH:0] dsr_ext;

   assign tmp_rem = {rem, quo[WIDTH-1]};
   assign dsr_ext = {1'b0, dsr};

   always_comb begin
      rem_next = tmp_rem[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
      if (tmp_rem >= dsr_ext) begin
         // Difference is always below dsr_ext, so the top bit is zero.
         rem_next = WIDTH'(tmp_rem - dsr_ext);
         quo_next = {quo[WIDTH-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/divu_hilo_unit.sv
// rtl/divu_hilo_unit.sv - unsigned iterative divider with HI/LO registers
// Purpose : restoring divu, one quotient bit per clock; quotient commits to
//           LO and remainder to HI on HiLo_ctrl; serves mfhi/mflo reads.
// Ports   : clk, rst_n        clock (rising) and async active-low reset
//           div_rst           1 holds idle / aborts; low in IDLE starts a divu
//           dividend, divisor operands, sampled on the start edge only
//           HiLo_ctrl         commit result to HI/LO (honoured in DONE only)
//           HiorLo            read select: 1 = HI, 0 = LO
//           hilo_data         selected HI/LO value
//           busy, done        RUN state / result ready and uncommitted
// Config  : HILO_FWD_EN - when defined, a commit is forwarded onto hilo_data
//           in the same cycle; otherwise hilo_data shows registered HI/LO.
module divu_hilo_unit
   import divu_hilo_unit_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             div_rst,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             HiLo_ctrl,
   input  logic             HiorLo,
   output logic [WIDTH-1:0] hilo_data,
   output logic             busy,
   output logic             done
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] dsr_q, dsr_d;
   logic [WIDTH-1:0] step_rem, step_quo;

   divu_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .dsr      (dsr_q),
      .rem_next (step_rem),
      .quo_next (step_quo)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      dsr_d   = dsr_q;
      case (state_q)
         DIV_IDLE: begin
            if (!div_rst) begin
               quo_d   = dividend;
               dsr_d   = divisor;
               rem_d   = '0;
               cnt_d   = '0;
               state_d = DIV_RUN;
            end
         end
         DIV_RUN: begin
            if (div_rst) begin
               cnt_d   = '0;
               state_d = DIV_IDLE;
            end else begin
               rem_d = step_rem;
               quo_d = step_quo;
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_STEP) begin
                  state_d = DIV_DONE;
               end
            end
         end
         DIV_DONE: begin
            // Commit takes priority over a simultaneous div_rst.
            if (HiLo_ctrl) begin
               hi_d    = rem_q;
               lo_d    = quo_q;
               state_d = DIV_IDLE;
            end else if (div_rst) begin
               state_d = DIV_IDLE;
            end
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dsr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dsr_q   <= dsr_d;
      end
   end

   assign busy = (state_q == DIV_RUN);
   assign done = (state_q == DIV_DONE);

`ifdef HILO_FWD_EN
   // hi_d/lo_d already carry rem/quo during a commit, and equal the
   // registers otherwise, so they double as the forwarding path.
   assign hilo_data = HiorLo ? hi_d : lo_d;
`else
   assign hilo_data = HiorLo ? hi_q : lo_q;
`endif

endmodule

// File: tb/tb_divu_hilo_unit.sv
// tb/tb_divu_hilo_unit.sv - scoreboard bench for divu_hilo_unit
module tb_divu_hilo_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         div_rst;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         HiLo_ctrl;
   logic         HiorLo;
   logic [W-1:0] hilo_data;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_pass   = 0;

   logic [63:0] sb[$];
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   divu_hilo_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .div_rst   (div_rst),
      .dividend  (dividend),
      .divisor   (divisor),
      .HiLo_ctrl (HiLo_ctrl),
      .HiorLo    (HiorLo),
      .hilo_data (hilo_data),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // Reference: {HI, LO} = {a mod b, a / b}; divide by zero yields {a, all ones}.
   function automatic logic [63:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      if (b == 0) return {a, {W{1'b1}}};
      return {a % b, a / b};
   endfunction

   // Monitor: checks the read port every cycle against the HI/LO model and
   // applies a queued result when the bench's commit pulse is observed.
   always @(negedge clk) begin
      logic [63:0] e;
      logic        pend;
      logic [W-1:0] exp_hi, exp_lo;
      pend = 1'b0;
      e    = '0;
      if (!rst_n) begin
         m_hi = '0;
         m_lo = '0;
         sb.delete();
      end else if (HiLo_ctrl && sb.size() > 0) begin
         e    = sb.pop_front();
         pend = 1'b1;
      end
      exp_hi = m_hi;
      exp_lo = m_lo;
`ifdef HILO_FWD_EN
      if (pend) begin
         exp_hi = e[63:32];
         exp_lo = e[31:0];
      end
`endif
      check(HiorLo ? "mon_mfhi" : "mon_mflo", hilo_data, HiorLo ? exp_hi : exp_lo);
      if (pend) begin
         m_hi = e[63:32];
         m_lo = e[31:0];
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      HiorLo = 1'($urandom);
   endtask

   // mode 0: commit in DONE; mode 1: discard with div_rst. early>0 pulses
   // HiLo_ctrl during RUN; hold>0 lingers in DONE with div_rst low.
   task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int mode, input int early, input int hold);
      div_rst  = 1'b0;
      dividend = a;
      divisor  = b;
      tick();                       // edge 1: start
      dividend = $urandom;          // operands must not be resampled
      divisor  = $urandom;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      for (int e = 2; e <= 33; e++) begin
         HiLo_ctrl = (e - 1 == early);
         tick();
         HiLo_ctrl = 1'b0;
         if (e == 32) check("done_before_33", {31'd0, done}, 32'd0);
      end
      check("done_at_33", {31'd0, done}, 32'd1);
      check("busy_at_33", {31'd0, busy}, 32'd0);
      for (int h = 0; h < hold; h++) begin
         tick();
         check("done_held", {31'd0, done}, 32'd1);
         check("no_restart", {31'd0, busy}, 32'd0);
      end
      if (mode == 0) begin
         sb.push_back(ref_div(a, b));
         HiLo_ctrl = 1'b1;
      end
      div_rst = 1'b1;
      tick();
      HiLo_ctrl = 1'b0;
      check("done_cleared", {31'd0, done}, 32'd0);
      tick();
   endtask

   initial begin
      rst_n     = 1'b0;
      div_rst   = 1'b1;
      dividend  = '0;
      divisor   = '0;
      HiLo_ctrl = 1'b0;
      HiorLo    = 1'b0;
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_hilo", hilo_data, 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      run_div(32'd100, 32'd7, 0, 0, 0);
      run_div(32'hFFFF_FFFF, 32'd1, 0, 0, 2);
      run_div(32'd5, 32'd9, 0, 0, 0);
      run_div(32'd1234, 32'd0, 0, 0, 0);
      run_div(32'd43, 32'd10, 0, 0, 0);        // HI=3, LO=4 preload

      // Abort at step 10: HI/LO untouched, later commit pulse ignored.
      div_rst  = 1'b0;
      dividend = 32'd50;
      divisor  = 32'd5;
      tick();
      for (int s = 1; s < 10; s++) tick();
      div_rst = 1'b1;
      tick();
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_done", {31'd0, done}, 32'd0);
      HiLo_ctrl = 1'b1;
      tick();
      HiLo_ctrl = 1'b0;
      check("abort_commit_busy", {31'd0, busy}, 32'd0);
      check("abort_commit_done", {31'd0, done}, 32'd0);
      tick();

      run_div(32'd80, 32'd3, 0, 5, 0);         // early commit ignored
      run_div(32'd999, 32'd13, 1, 0, 1);       // discarded result

      for (int i = 0; i < 20; i++) begin
         logic [W-1:0] a, b;
         a = $urandom;
         case (i % 4)
            0: b = 32'd0;
            1: b = $urandom_range(1, 15);
            2: b = a;
            default: b = $urandom;
         endcase
         run_div(a, b, (i % 5 == 4) ? 1 : 0, (i % 3 == 0) ? int'($urandom_range(1, 30)) : 0, i % 2);
      end

      // Async reset in the middle of RUN.
      div_rst  = 1'b0;
      dividend = 32'd1000;
      divisor  = 32'd7;
      tick();
      for (int s = 1; s < 10; s++) tick();
      #1;
      rst_n   = 1'b0;
      div_rst = 1'b1;
      HiorLo  = 1'b1;
      #1;
      check("async_rst_hi", hilo_data, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      check("async_rst_done", {31'd0, done}, 32'd0);
      HiorLo = 1'b0;
      #1;
      check("async_rst_lo", hilo_data, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      run_div(32'd77, 32'd8, 0, 0, 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
